// File: rtl/intc_vec.sv
// Vectored interrupt controller: synchronises, latches, masks and prioritises NUM_CH lines.
// Optional macro INTC_EDGE_EN adds per-channel edge latching (mode register and third sync stage).
module intc_vec #(
  parameter int                 NUM_CH   = 8,
  parameter int                 VEC_W    = 10,
  parameter logic [VEC_W-1:0]   VEC_BASE = 10'h3F0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           irq_in,
  input  logic                        i_set,
  input  logic                        i_clr,
  input  logic                        mask_we,
  input  logic [NUM_CH-1:0]           mask_din,
  input  logic                        mode_we,
  input  logic [NUM_CH-1:0]           mode_din,
  input  logic                        irq_ack,
  input  logic                        irq_eoi,
  output logic                        irq_req,
  output logic [$clog2(NUM_CH)-1:0]   irq_id,
  output logic [VEC_W-1:0]            vec_addr,
  output logic                        ien_q,
  output logic                        isr_act,
  output logic [$clog2(NUM_CH)-1:0]   isr_id,
  output logic [NUM_CH-1:0]           pend_q
);

  localparam int IDW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] s1, s2, pend, mask, elig, pend_next;
  logic [IDW-1:0]    win, act_id;
  logic              ien, act, take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
    end
  end

  assign elig = pend & mask;

  // Fixed priority: scanning downward leaves the lowest set index as the winner.
  always_comb begin
    win = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (elig[n]) win = IDW'(n);
    end
  end

  assign irq_req = (|elig) & ien & ~act;
  assign take    = irq_ack & irq_req;

`ifdef INTC_EDGE_EN
  logic [NUM_CH-1:0] s3, mode, ack_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3   <= '0;
      mode <= '0;
    end else begin
      s3 <= s2;
      if (mode_we) mode <= mode_din;
    end
  end

  always_comb begin
    ack_clr = '0;
    if (take) ack_clr[win] = 1'b1;
  end

  // A new edge is OR-ed in after the ack clear, so a simultaneous set wins.
  assign pend_next = (mode & ((pend & ~ack_clr) | (s2 & ~s3))) | (~mode & s2);
`else
  logic unused_mode;
  assign unused_mode = mode_we ^ (^mode_din);
  assign pend_next   = s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      mask   <= '0;
      ien    <= 1'b0;
      act    <= 1'b0;
      act_id <= '0;
    end else begin
      pend <= pend_next;
      if (mask_we) mask <= mask_din;
      if (i_clr || take) ien <= 1'b0;
      else if (i_set)    ien <= 1'b1;
      if (take) begin
        act    <= 1'b1;
        act_id <= win;
      end else if (irq_eoi) begin
        act <= 1'b0;
      end
    end
  end

  assign irq_id   = win;
  assign vec_addr = VEC_BASE + VEC_W'(win);
  assign ien_q    = ien;
  assign isr_act  = act;
  assign isr_id   = act_id;
  assign pend_q   = pend;

endmodule

// File: tb/tb_intc_vec.sv
// Self-checking bench for intc_vec: directed scenarios plus random traffic against a history-based model.
// Edge-mode scenarios are built only when INTC_EDGE_EN is defined.
module tb_intc_vec;

`ifdef INTC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk, reset;
  logic [7:0] irq_in, mask_din, mode_din;
  logic       i_set, i_clr, mask_we, mode_we, irq_ack, irq_eoi;
  logic       irq_req, ien_q, isr_act;
  logic [2:0] irq_id, isr_id;
  logic [9:0] vec_addr;
  logic [7:0] pend_q;

  int error_count = 0;
  int check_count = 0;

  intc_vec #(.NUM_CH(8), .VEC_W(10), .VEC_BASE(10'h3F0)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .i_set(i_set), .i_clr(i_clr),
    .mask_we(mask_we), .mask_din(mask_din), .mode_we(mode_we), .mode_din(mode_din),
    .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_req(irq_req), .irq_id(irq_id),
    .vec_addr(vec_addr), .ien_q(ien_q), .isr_act(isr_act), .isr_id(isr_id), .pend_q(pend_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: samples[2] is irq_in seen one edge ago, samples[1] two edges ago, samples[0] three.
  logic [7:0] samples[$];
  logic [7:0] m_pend, m_mask, m_mode;
  logic       m_ien, m_act;
  int         m_id;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit model_req();
    return ((m_pend & m_mask) != 8'h00) && m_ien && !m_act;
  endfunction

  task automatic model_reset();
    samples = {};
    repeat (3) samples.push_back(8'h00);
    m_pend = '0; m_mask = '0; m_mode = '0;
    m_ien = 1'b0; m_act = 1'b0; m_id = 0;
  endtask

  task automatic model_edge();
    int         win  = lowest(m_pend & m_mask);
    bit         fire = irq_ack && model_req();
    logic [7:0] seen = samples[1];
    logic [7:0] rise = samples[1] & ~samples[0];
    logic [7:0] np;
    for (int n = 0; n < 8; n++) begin
      if (EDGE_EN && m_mode[n])
        np[n] = rise[n] | (m_pend[n] && !(fire && win == n));
      else
        np[n] = seen[n];
    end
    m_pend = np;
    samples.push_back(irq_in);
    void'(samples.pop_front());
    if (mask_we) m_mask = mask_din;
    if (EDGE_EN && mode_we) m_mode = mode_din;
    if (i_clr || fire) m_ien = 1'b0;
    else if (i_set) m_ien = 1'b1;
    if (fire) begin
      m_act = 1'b1;
      m_id  = win;
    end else if (irq_eoi) begin
      m_act = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compare_all(input string tag);
    int id = lowest(m_pend & m_mask);
    checkOutput({tag, ".req"},  32'(irq_req),  32'(model_req()));
    checkOutput({tag, ".id"},   32'(irq_id),   id);
    checkOutput({tag, ".vec"},  32'(vec_addr), 32'h3F0 + id);
    checkOutput({tag, ".ien"},  32'(ien_q),    32'(m_ien));
    checkOutput({tag, ".act"},  32'(isr_act),  32'(m_act));
    checkOutput({tag, ".isr"},  32'(isr_id),   m_id);
    checkOutput({tag, ".pend"}, 32'(pend_q),   32'(m_pend));
  endtask

  task automatic applyStimulus(input logic [7:0] irq, input logic ack, input logic eoi,
                               input logic set, input logic clr,
                               input logic mwe, input logic [7:0] mdin,
                               input logic owe, input logic [7:0] odin);
    irq_in = irq; irq_ack = ack; irq_eoi = eoi; i_set = set; i_clr = clr;
    mask_we = mwe; mask_din = mdin; mode_we = owe; mode_din = odin;
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
  endtask

  task automatic idle(input logic [7:0] irq, input int n);
    repeat (n) applyStimulus(irq, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  // Reset is asserted between edges so the outputs must clear with no clock edge.
  task automatic pulseReset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all("rst");
    checkOutput("rst.vec_base", 32'(vec_addr), 32'h3F0);
    checkOutput("rst.req_low", 32'(irq_req), 0);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] r_irq, flip;
    reset = 1'b1;
    irq_in = '0; irq_ack = 0; irq_eoi = 0; i_set = 0; i_clr = 0;
    mask_we = 0; mask_din = '0; mode_we = 0; mode_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("init");
    checkOutput("init.vec_base", 32'(vec_addr), 32'h3F0);
    reset = 1'b0;

    // Priority between two simultaneous sources.
    applyStimulus(8'h00, 0, 0, 1, 0, 1, 8'hFF, 0, 8'h00);
    idle(8'h24, 3);
    checkOutput("prio.req", 32'(irq_req), 1);
    checkOutput("prio.id", 32'(irq_id), 2);
    checkOutput("prio.vec", 32'(vec_addr), 32'h3F2);
    applyStimulus(8'h24, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("prio.ack_act", 32'(isr_act), 1);
    checkOutput("prio.ack_isr", 32'(isr_id), 2);
    checkOutput("prio.ack_req", 32'(irq_req), 0);
    idle(8'h20, 3);
    applyStimulus(8'h20, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("prio.next_id", 32'(irq_id), 5);
    checkOutput("prio.next_vec", 32'(vec_addr), 32'h3F5);
    applyStimulus(8'h20, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    idle(8'h00, 3);
    applyStimulus(8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00);

    // Level source held through ack and EOI.
    idle(8'h00, 1);
    applyStimulus(8'h02, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    idle(8'h02, 2);
    checkOutput("lvl.req", 32'(irq_req), 1);
    checkOutput("lvl.id", 32'(irq_id), 1);
    applyStimulus(8'h02, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("lvl.ack_req", 32'(irq_req), 0);
    applyStimulus(8'h02, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("lvl.reassert", 32'(irq_req), 1);
    idle(8'h00, 3);
    checkOutput("lvl.drop", 32'(pend_q[1]), 0);

    // Controls that must have no effect, and CLI beating SEI.
    applyStimulus(8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("ign.ack_act", 32'(isr_act), 0);
    checkOutput("ign.ack_ien", 32'(ien_q), 1);
    applyStimulus(8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00);
    checkOutput("ign.setclr", 32'(ien_q), 0);
    applyStimulus(8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("ign.eoi", 32'(isr_act), 0);

    // Reset in the middle of a handler with sources pending.
    applyStimulus(8'h05, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00);
    idle(8'h05, 3);
    applyStimulus(8'h05, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    idle(8'h05, 1);
    pulseReset();
    idle(8'h00, 4);

`ifdef INTC_EDGE_EN
    // Masked edge stays latched until unmasked.
    applyStimulus(8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 8'h09);
    idle(8'h08, 1);
    idle(8'h00, 3);
    checkOutput("edge.pend", 32'(pend_q), 32'h08);
    checkOutput("edge.masked", 32'(irq_req), 0);
    applyStimulus(8'h00, 0, 0, 0, 0, 1, 8'h08, 0, 8'h00);
    checkOutput("edge.unmask", 32'(irq_req), 1);
    applyStimulus(8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("edge.ack_clr", 32'(pend_q[3]), 0);
    applyStimulus(8'h00, 0, 1, 1, 0, 1, 8'hFF, 0, 8'h00);

    // New edge on channel 0 arrives on the very edge that acks channel 0.
    idle(8'h01, 1);
    idle(8'h00, 2);
    checkOutput("race.req", 32'(irq_req), 1);
    idle(8'h01, 1);
    idle(8'h00, 1);
    applyStimulus(8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("race.pend0", 32'(pend_q[0]), 1);
    checkOutput("race.isr", 32'(isr_id), 0);
    checkOutput("race.act", 32'(isr_act), 1);
    applyStimulus(8'h00, 0, 1, 1, 0, 0, 8'h00, 0, 8'h00);
`endif

    // Random traffic against the model.
    r_irq = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      flip = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) flip[b] = 1'b1;
      r_irq ^= flip;
      if ($urandom_range(299) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(r_irq,
                      model_req() ? 1'($urandom_range(1)) : 1'($urandom_range(15) == 0),
                      1'($urandom_range(7) == 0),
                      1'($urandom_range(3) == 0),
                      1'($urandom_range(15) == 0),
                      1'($urandom_range(15) == 0), 8'($urandom),
                      1'($urandom_range(15) == 0), 8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
